cordic_frame_sequencer: RTL and testbench

Frame-level controller for the shared rectangular-to-polar CORDIC core (18-bit x/y in, 24-bit magnitude/phase out, nd/rdy strobes). On `start` it walks every bin of the FFT output RAM, streams real/imag pairs into the CORDIC one per cycle, and tags each result with its bin index. It writes magnitude/phase to the spectrum RAM and tracks the peak-magnitude bin for the pitch detector. It sits between the FFT output buffer and the pitch-estimation logic.

---
 rtl/cordic_frame_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_cordic_frame_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_frame_sequencer.sv
// Frame sequencer for the shared rectangular-to-polar CORDIC: streams FFT bins in, tags results
// with their bin index through a FIFO, writes the spectrum RAM and tracks the peak bin.
module cordic_frame_sequencer #(
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned CORDIC_LAT = 20,
   parameter int unsigned TAG_DEPTH  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] fft_addr,
   input  logic [17:0]       fft_re,
   input  logic [17:0]       fft_im,
   output logic [17:0]       cx_in,
   output logic [17:0]       cy_in,
   output logic              cnd,
   input  logic [23:0]       c_mag,
   input  logic [23:0]       c_phase,
   input  logic              crdy,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [23:0]       wr_mag,
   output logic [23:0]       wr_phase,
   output logic [ADDR_W-1:0] peak_bin,
   output logic [23:0]       peak_mag,
   output logic              err_orphan
);
   localparam int unsigned BINS   = 1 << ADDR_W;
   localparam int unsigned CntW   = ADDR_W + 1;
   localparam int unsigned PtrW   = $clog2(TAG_DEPTH);
   localparam int unsigned FlushW = $clog2(CORDIC_LAT + 3);
   localparam logic [FlushW-1:0] FlushLast = FlushW'(CORDIC_LAT + 1);
   localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(BINS - 1);
   localparam logic [CntW-1:0]   BinsCnt   = CntW'(BINS);

   typedef enum logic [2:0] {StFlush, StIdle, StIssue, StDrain, StDone} state_e;

   state_e              state_q, state_d;
   logic [FlushW-1:0]   flush_cnt_q;
   logic [ADDR_W-1:0]   rd_cnt_q;
   logic                v_q;
   logic [ADDR_W-1:0]   tag_in_q;
   logic [CntW-1:0]     ret_cnt_q, ret_cnt_d;
   logic [ADDR_W-1:0]   run_bin_q, run_bin_d;
   logic [23:0]         run_mag_q, run_mag_d;
   logic [ADDR_W-1:0]   peak_bin_q;
   logic [23:0]         peak_mag_q;
   logic                orphan_q;

   logic [ADDR_W-1:0]   tag_mem [TAG_DEPTH];
   logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]       fifo_cnt_q;
   logic [ADDR_W-1:0]   tag_head;
   logic                fifo_empty, push, pop, in_band, clear;
   logic                accept_rdy, orphan_chk, issue;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StFlush;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StFlush: if (flush_cnt_q == FlushLast) state_d = StIdle;
         StIdle:  if (start) state_d = StIssue;
         StIssue: if (rd_cnt_q == LastAddr) state_d = StDrain;
         StDrain: if (ret_cnt_d == BinsCnt) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StFlush;
      endcase
   end

   // State-decoded outputs and qualifiers
   always_comb begin
      busy       = 1'b1;
      done       = 1'b0;
      accept_rdy = 1'b0;
      orphan_chk = 1'b0;
      issue      = 1'b0;
      case (state_q)
         StIdle: begin
            busy       = 1'b0;
            orphan_chk = 1'b1;
         end
         StIssue: begin
            accept_rdy = 1'b1;
            orphan_chk = 1'b1;
            issue      = 1'b1;
         end
         StDrain: begin
            accept_rdy = 1'b1;
            orphan_chk = 1'b1;
         end
         StDone:  done = 1'b1;
         default: ;
      endcase
   end

   assign tag_head   = tag_mem[rd_ptr_q];
   assign fifo_empty = (fifo_cnt_q == '0);
   assign push       = v_q;
   assign pop        = accept_rdy & crdy & ~fifo_empty;
   assign clear      = (state_q == StIdle) & start;
   assign ret_cnt_d  = ret_cnt_q + CntW'(pop);
   // Peak search skips DC and the negative-frequency half
   assign in_band    = (tag_head != '0) & ~tag_head[ADDR_W-1];

   always_comb begin
      run_bin_d = run_bin_q;
      run_mag_d = run_mag_q;
      if (clear) begin
         run_bin_d = '0;
         run_mag_d = '0;
      end else if (pop && in_band && (c_mag > run_mag_q)) begin
         run_bin_d = tag_head;
         run_mag_d = c_mag;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flush_cnt_q <= '0;
         rd_cnt_q    <= '0;
         v_q         <= 1'b0;
         tag_in_q    <= '0;
         ret_cnt_q   <= '0;
         run_bin_q   <= '0;
         run_mag_q   <= '0;
         peak_bin_q  <= '0;
         peak_mag_q  <= '0;
         orphan_q    <= 1'b0;
      end else begin
         if (state_q == StFlush) flush_cnt_q <= flush_cnt_q + FlushW'(1);
         v_q       <= issue;
         tag_in_q  <= rd_cnt_q;
         run_bin_q <= run_bin_d;
         run_mag_q <= run_mag_d;
         if (clear) begin
            rd_cnt_q  <= '0;
            ret_cnt_q <= '0;
         end else begin
            if (issue) rd_cnt_q <= rd_cnt_q + ADDR_W'(1);
            ret_cnt_q <= ret_cnt_d;
         end
         // Load on entry to DONE so the result is valid alongside the done pulse
         if (state_d == StDone && state_q != StDone) begin
            peak_bin_q <= run_bin_d;
            peak_mag_q <= run_mag_d;
         end
         if (orphan_chk && crdy && fifo_empty) orphan_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr_q] <= tag_in_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         case ({push, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + (PtrW+1)'(1);
            2'b01:   fifo_cnt_q <= fifo_cnt_q - (PtrW+1)'(1);
            default: ;
         endcase
      end
   end

   assign fft_addr   = rd_cnt_q;
   assign cnd        = v_q;
   assign cx_in      = v_q ? fft_re : '0;
   assign cy_in      = v_q ? fft_im : '0;
   assign wr_en      = pop;
   assign wr_addr    = pop ? tag_head : '0;
   assign wr_mag     = pop ? c_mag : '0;
   assign wr_phase   = pop ? c_phase : '0;
   assign peak_bin   = peak_bin_q;
   assign peak_mag   = peak_mag_q;
   assign err_orphan = orphan_q;

endmodule

// File: tb/tb_cordic_frame_sequencer.sv
// Bench for cordic_frame_sequencer: FFT RAM and CORDIC stand-ins, frame-level reference model
// for write order, timing and peak search, plus reset/orphan corner cases.
module tb_cordic_frame_sequencer;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned LAT    = 4;
   localparam int unsigned BINS   = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset, start, busy, done, cnd, crdy, wr_en, err_orphan;
   logic [ADDR_W-1:0] fft_addr, wr_addr, peak_bin;
   logic [17:0]       fft_re, fft_im, cx_in, cy_in;
   logic [23:0]       c_mag, c_phase, wr_mag, wr_phase, peak_mag;

   logic [17:0]       mem_re [BINS];
   logic [17:0]       mem_im [BINS];
   logic [LAT-1:0]    pv = '0;
   logic [23:0]       pm [LAT];
   logic [23:0]       pp [LAT];
   logic              inj = 1'b0;
   logic              exp_orphan = 1'b0;
   int                checks = 0;
   int                errors = 0;

   cordic_frame_sequencer #(.ADDR_W(ADDR_W), .CORDIC_LAT(LAT), .TAG_DEPTH(8)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .fft_addr(fft_addr), .fft_re(fft_re), .fft_im(fft_im),
      .cx_in(cx_in), .cy_in(cy_in), .cnd(cnd),
      .c_mag(c_mag), .c_phase(c_phase), .crdy(crdy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_mag(wr_mag), .wr_phase(wr_phase),
      .peak_bin(peak_bin), .peak_mag(peak_mag), .err_orphan(err_orphan)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] mag_f(input logic [17:0] x, input logic [17:0] y);
      return {x[11:0], y[11:0]};
   endfunction

   function automatic logic [23:0] ph_f(input logic [17:0] x, input logic [17:0] y);
      return {y[5:0], x} ^ 24'h5A5A5A;
   endfunction

   // Synchronous-read FFT RAM and fixed-latency CORDIC stand-in
   always @(posedge clk) begin
      fft_re <= mem_re[fft_addr];
      fft_im <= mem_im[fft_addr];
      pv     <= {pv[LAT-2:0], cnd};
      pm[0]  <= mag_f(cx_in, cy_in);
      pp[0]  <= ph_f(cx_in, cy_in);
      for (int i = 1; i < LAT; i++) begin
         pm[i] <= pm[i-1];
         pp[i] <= pp[i-1];
      end
   end
   assign crdy    = pv[LAT-1] | inj;
   assign c_mag   = pm[LAT-1];
   assign c_phase = pp[LAT-1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mag(input int b, input logic [23:0] m);
      mem_re[b] = {6'd0, m[23:12]};
      mem_im[b] = {6'd0, m[11:0]};
   endtask

   task automatic model_peak(output logic [ADDR_W-1:0] pb, output logic [23:0] pk);
      pb = '0;
      pk = '0;
      for (int i = 1; i < BINS / 2; i++) begin
         if (mag_f(mem_re[i], mem_im[i]) > pk) begin
            pk = mag_f(mem_re[i], mem_im[i]);
            pb = ADDR_W'(i);
         end
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 40) begin
         tick();
         n++;
      end
      chk("idle_reached", {31'd0, busy}, 32'd0);
   endtask

   // start pulsed at cycle 0; optional extra start pulses at cycles s1/s2
   task automatic run_frame(input int s1, input int s2);
      int cyc = 0;
      int nwr = 0;
      bit fin = 1'b0;
      logic [ADDR_W-1:0] epb;
      logic [23:0] epm;
      model_peak(epb, epm);
      start = 1'b1;
      while (!fin && cyc < 60) begin
         tick();
         cyc++;
         start = (cyc == s1 || cyc == s2);
         chk("cnd", {31'd0, cnd}, {31'd0, (cyc >= 2 && cyc <= BINS + 1)});
         if (cnd && cyc >= 2 && cyc <= BINS + 1) begin
            chk("cx_in", 32'(cx_in), 32'(mem_re[cyc-2]));
            chk("cy_in", 32'(cy_in), 32'(mem_im[cyc-2]));
         end
         if (cyc <= BINS) chk("fft_addr", 32'(fft_addr), 32'(cyc - 1));
         if (wr_en && nwr < BINS) begin
            chk("wr_addr", 32'(wr_addr), 32'(nwr));
            chk("wr_mag", 32'(wr_mag), 32'(mag_f(mem_re[nwr], mem_im[nwr])));
            chk("wr_phase", 32'(wr_phase), 32'(ph_f(mem_re[nwr], mem_im[nwr])));
            chk("wr_cycle", 32'(cyc), 32'(2 + LAT + nwr));
            nwr++;
         end
         chk("done", {31'd0, done}, {31'd0, (cyc == BINS + 2 + LAT)});
         chk("busy", {31'd0, busy}, {31'd0, (cyc <= BINS + 2 + LAT)});
         if (cyc == BINS + 3 + LAT) fin = 1'b1;
      end
      start = 1'b0;
      chk("frame_end", {31'd0, fin}, 32'd1);
      chk("write_count", 32'(nwr), 32'(BINS));
      chk("peak_bin", 32'(peak_bin), 32'(epb));
      chk("peak_mag", 32'(peak_mag), 32'(epm));
      chk("err_orphan", {31'd0, err_orphan}, {31'd0, exp_orphan});
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      for (int i = 0; i < BINS; i++) begin
         mem_re[i] = 18'(i * 1000 + 7);
         mem_im[i] = 18'(3 * i + 1);
      end
      tick();
      tick();
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_outs", {28'd0, done, cnd, wr_en, err_orphan}, 32'd0);
      chk("rst_data", 32'(fft_addr) | 32'(cx_in) | 32'(cy_in) | 32'(wr_addr) | 32'(wr_mag)
          | 32'(wr_phase) | 32'(peak_bin) | 32'(peak_mag), 32'd0);
      reset = 1'b0;
      wait_idle();

      // Ramp frame: timing and write order
      run_frame(-1, -1);

      // Peak rules: DC / upper half excluded, unsigned compare, lowest bin on ties
      for (int i = 0; i < BINS; i++) set_mag(i, 24'd100);
      set_mag(0, 24'd900);
      set_mag(3, 24'd500);
      set_mag(6, 24'd800);
      run_frame(-1, -1);
      chk("peak3_bin", 32'(peak_bin), 32'd3);
      for (int i = 0; i < BINS; i++) set_mag(i, 24'd0);
      set_mag(1, 24'h7FFFFF);
      set_mag(2, 24'h7FFFFF);
      run_frame(-1, -1);
      chk("tie_bin", 32'(peak_bin), 32'd1);
      set_mag(2, 24'hFFFFFF);
      set_mag(3, 24'hFFFFFF);
      run_frame(-1, -1);
      chk("unsigned_bin", 32'(peak_bin), 32'd2);

      // Starts mid-frame and on the DONE cycle are ignored
      run_frame(5, BINS + 2 + LAT);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("no_refire_busy", {31'd0, busy}, 32'd0);
         chk("no_refire_done", {31'd0, done}, 32'd0);
      end

      // Reset mid-frame, then flush swallows crdy and start
      start = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         start = 1'b0;
      end
      reset = 1'b1;
      #1;
      chk("mrst_busy", {31'd0, busy}, 32'd1);
      chk("mrst_outs", {28'd0, done, cnd, wr_en, err_orphan}, 32'd0);
      chk("mrst_data", 32'(fft_addr) | 32'(cx_in) | 32'(cy_in) | 32'(wr_addr) | 32'(wr_mag)
          | 32'(peak_bin) | 32'(peak_mag), 32'd0);
      tick();
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         inj = 1'b1;
         start = (k == 2);
         #1;
         chk("flush_wr_en", {31'd0, wr_en}, 32'd0);
         chk("flush_busy", {31'd0, busy}, 32'd1);
         tick();
         chk("flush_orphan", {31'd0, err_orphan}, 32'd0);
      end
      inj = 1'b0;
      start = 1'b0;
      wait_idle();
      for (int i = 0; i < BINS; i++) begin
         mem_re[i] = 18'($urandom);
         mem_im[i] = 18'($urandom);
      end
      run_frame(-1, -1);

      // Spurious crdy in IDLE sets the sticky orphan flag
      inj = 1'b1;
      #1;
      chk("orphan_wr_en", {31'd0, wr_en}, 32'd0);
      tick();
      inj = 1'b0;
      exp_orphan = 1'b1;
      chk("orphan_set", {31'd0, err_orphan}, 32'd1);

      // Random frames against the reference model
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < BINS; i++) begin
            mem_re[i] = 18'($urandom);
            mem_im[i] = 18'($urandom);
         end
         if (f == 1) mem_re[$urandom_range(1, BINS / 2 - 1)][11:0] = 12'hFFF;
         run_frame(-1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
